// File: rtl/shift_pkg.sv
// Shared definitions for the bit-serial shift unit: operation and state
// encodings, widths, and the per-bit index/fill computation.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Mux control for one result bit: which source bit to pick, and whether
    // the picked bit is replaced by a fill value.
    typedef struct packed {
        logic [SHAMT_W-1:0] sel;
        logic               fill_en;
        logic               fill_val;
    } mux_ctl_t;

    // Index arithmetic is done on 6 bits so that bit 5 flags underflow for
    // left shifts and overflow past bit 31 for right shifts. The mux select
    // is always the low 5 bits; out-of-range positions become fill bits.
    function automatic mux_ctl_t mux_ctl(
        input op_t                op,
        input logic [SHAMT_W-1:0] idx,
        input logic [SHAMT_W-1:0] amt,
        input logic               msb
    );
        mux_ctl_t   ctl;
        logic [5:0] diff;
        logic [5:0] sum;
        diff         = {1'b0, idx} - {1'b0, amt};
        sum          = {1'b0, idx} + {1'b0, amt};
        ctl.sel      = sum[4:0];
        ctl.fill_en  = 1'b0;
        ctl.fill_val = 1'b0;
        case (op)
            OP_SLL: begin
                ctl.sel     = diff[4:0];
                ctl.fill_en = diff[5];
            end
            OP_SRL: begin
                ctl.fill_en = sum[5];
            end
            OP_SRA: begin
                ctl.fill_en  = sum[5];
                ctl.fill_val = msb;
            end
            OP_ROR: begin
                ctl.fill_en = 1'b0;
            end
            default: begin
                ctl.fill_en = 1'b0;
            end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mux32_1.sv
// 32-to-1 single-bit multiplexer; picks source[select].
module mux32_1 (
    input  logic [31:0] source,
    input  logic [4:0]  select,
    output logic        result
);

    assign result = source[select];

endmodule

// File: rtl/serial_shifter.sv
// Bit-serial 32-bit shifter (sll/srl/sra/ror). One result bit per clock is
// produced through a single mux32_1 plus a fill override.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; result holds the last completed value
// S_BUSY | writing result[cnt] each edge, cnt 0..31
// S_DONE | one-cycle done pulse; a start here is accepted back-to-back
module serial_shifter
    import shift_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DATA_W-1:0]   src,
    input  logic [SHAMT_W-1:0]  shamt,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   result
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                last_bit;

    op_t                 op_q;
    logic [DATA_W-1:0]   src_q;
    logic [SHAMT_W-1:0]  shamt_q;
    logic [SHAMT_W-1:0]  cnt;

    mux_ctl_t            ctl;
    logic                mux_bit;
    logic                bit_val;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs. Accepting from S_DONE gives
    // the 33-cycle minimum issue interval when start is held high.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (cnt == SHAMT_W'(DATA_W - 1)) begin
                    last_bit  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_BUSY;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-bit mux control from the latched operands and the bit counter.
    always_comb begin
        ctl     = mux_ctl(op_q, cnt, shamt_q, src_q[DATA_W-1]);
        bit_val = ctl.fill_en ? ctl.fill_val : mux_bit;
    end

    mux32_1 u_mux (
        .source (src_q),
        .select (ctl.sel),
        .result (mux_bit)
    );

    // Operand latch, bit counter and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_SLL;
            src_q   <= '0;
            shamt_q <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (accept) begin
            op_q    <= op_t'(op);
            src_q   <= src;
            shamt_q <= shamt;
            cnt     <= '0;
            result  <= '0;
        end else if (state == S_BUSY) begin
            result[cnt] <= bit_val;
            if (!last_bit) begin
                cnt <= cnt + SHAMT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed timing cases plus random
// operations scored against an arithmetic reference model.
module tb_serial_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_vec;
    int          n_err;
    int          done_cnt;
    logic [31:0] exp_q[$];

    serial_shifter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src    (src),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] s, input int sh);
        logic [63:0] w;
        logic [31:0] r;
        case (o)
            2'b00:   r = s << sh;
            2'b01:   r = s >> sh;
            2'b10:   begin w = {s, s} >> sh; r = w[31:0]; end
            default: r = 32'($signed(s) >>> sh);
        endcase
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: result %h with no operation pending", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    // Drive one accepted start; returns 1 ns after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] s, input logic [4:0] sh, input bit expect_done);
        if (expect_done) exp_q.push_back(model(o, s, int'(sh)));
        op    = o;
        src   = s;
        shamt = sh;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (!busy) return;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] s, input logic [4:0] sh);
        issue(o, s, sh, 1'b1);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int first_k;
        int second_k;
        int snap;
        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        src      = '0;
        shamt    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // sll 1<<4 with latency and busy-length checks
        issue(2'b00, 32'h0000_0001, 5'd4, 1'b1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin seen = k; break; end
        end
        check("done_latency", seen, 32);
        @(posedge clk);
        #1;
        check("done_width", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);

        run_op(2'b01, 32'h8000_0000, 5'd31);
        run_op(2'b11, 32'h8000_0000, 5'd31);
        run_op(2'b11, 32'h8000_0000, 5'd4);
        run_op(2'b10, 32'h0000_00F1, 5'd4);

        // shamt 0 on every op; second start at E10 of the first is ignored
        snap = done_cnt;
        issue(2'b00, 32'hDEAD_BEEF, 5'd0, 1'b1);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_done_count", done_cnt - snap, 1);
        run_op(2'b01, 32'hDEAD_BEEF, 5'd0);
        run_op(2'b10, 32'hDEAD_BEEF, 5'd0);
        run_op(2'b11, 32'hDEAD_BEEF, 5'd0);

        // asynchronous reset between E10 and E11 aborts without done
        issue(2'b00, 32'hFFFF_FFFF, 5'd3, 1'b0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        snap = done_cnt;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - snap, 0);
        run_op(2'b00, 32'h0000_0001, 5'd1);

        // back-to-back with start held high
        exp_q.push_back(model(2'b01, 32'hCAFE_1234, 8));
        op    = 2'b01;
        src   = 32'hCAFE_1234;
        shamt = 5'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(2'b11, 32'h9000_0005, 3));
        op       = 2'b11;
        src      = 32'h9000_0005;
        shamt    = 5'd3;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (k == 33) start = 1'b0;
            if (done && first_k == 0) first_k = k;
            else if (done && second_k == 0) second_k = k;
        end
        check("b2b_first_done", first_k, 32);
        check("b2b_second_done", second_k, 65);
        wait_idle();

        // random operations
        for (int n = 0; n < 40; n++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
